crossing_request: RTL
=====================

Name: crossing_request

Overview:
Upstream stage of the intersection light controller. It takes raw pedestrian push-buttons for the two roads (NS, WE), then synchronises and debounces them. Each press is latched as a request that stays up until the controller acknowledges the corresponding green phase. After an acknowledge, a hold-off measured in 1 s ticks suppresses immediate re-requests. The block also reports which pending request is oldest, so the controller can arbitrate.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive CLK cycles a synchronised button level must differ from the stable level before it is accepted (>=1)
HOLDOFF_S, 3, number of tick pulses a channel ignores presses after ack (0 = no hold-off)
CW, 5, debounce counter width; must hold DEBOUNCE_CYCLES-1

Ports:
CLK  in  1  system clock
Reset  in  1  asynchronous, active-low reset
btn  in  2  raw buttons, active-high, asynchronous; bit0=NS, bit1=WE
tick  in  1  one-CLK-cycle pulse per second from the controller's divider
ack  in  2  one-cycle pulse from controller: request of channel i served
req  out  2  latched request per channel, level
oldest  out  1  index of the earlier pending request; valid only when req==2'b11
holdoff  out  2  channel i is in hold-off (drives the "wait" indicator)
press  out  2  one-cycle pulse on each accepted debounced rising edge (debug/count)

Behaviour:
- Reset (Reset=0, async): synchronisers, stable levels, counters = 0; every channel in IDLE; req=0, oldest=0, holdoff=0, press=0. All outputs are registered.
- Synchroniser: two flops per bit; sync = second flop.
- Debounce, per channel:
  - If sync==stable: cnt<=0.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1: stable<=sync and cnt<=0; else cnt<=cnt+1.
  - A mismatch that lasts fewer than DEBOUNCE_CYCLES consecutive cycles leaves stable unchanged.
- Edge: press[i]<=stable&~stable_q, registered. Falling edges are debounced but produce no event.
- Latency: raw btn high sampled at edge 1. stable rises at edge DEBOUNCE_CYCLES+2. press and req rise at edge DEBOUNCE_CYCLES+3.
- Per-channel FSM, states IDLE, PENDING, HOLD:
  - IDLE: a press edge moves to PENDING and sets req=1. ack is ignored.
  - PENDING: req=1 and further presses are ignored. On ack: if HOLDOFF_S==0 go to IDLE (req=0), else go to HOLD with hcnt<=HOLDOFF_S and req=0.
  - HOLD: holdoff=1 and presses are discarded. On tick: if hcnt==1 go to IDLE, else hcnt<=hcnt-1. ack is ignored.
- Simultaneous events:
  - press and ack in the same cycle in IDLE: press wins (goes to PENDING).
  - ack and press in PENDING: ack wins; the press is lost.
  - tick and press on the last HOLD cycle: go to IDLE; the press is discarded.
- Oldest tracking:
  - When a channel enters PENDING while the other is not pending, oldest<=that channel.
  - If both enter PENDING in the same cycle, oldest<=0 (NS).
  - When the oldest channel leaves PENDING while the other remains, oldest<=other.
  - oldest holds its value otherwise.
- Reset mid-operation clears everything immediately. A button held through reset release is seen as a new press, once debounced.

Decomposition:
- Package crossing_pkg:
  - FSM state encoding (IDLE=2'b00, PENDING=2'b01, HOLD=2'b10).
  - Channel indices CH_NS=0, CH_WE=1.
  - Default DEBOUNCE_CYCLES and HOLDOFF_S.
- Sub-module btn_debounce (synchroniser + counter + stable + registered rising-edge pulse), instantiated once per channel. The FSMs, hold-off counters and oldest logic live in crossing_request.

Test Plan:
- Parameters for all scenarios: DEBOUNCE_CYCLES=4, HOLDOFF_S=3.
- Clean press: btn[0] rises, held 20 cycles -> press[0] one pulse and req[0]=1 exactly after edge 7; req[1] stays 0.
- Glitch: btn[1] high 3 cycles, then low -> no press, req[1]=0; repeat with bounces of 1–3 cycles then steady high -> one press only.
- Handshake and hold-off: req[0]=1, ack[0] pulse -> next cycle req[0]=0, holdoff[0]=1.
  - Press during hold-off is ignored.
  - After the 3rd tick, holdoff[0]=0.
  - A new press then gives req[0]=1.
- Arbitration: press WE, 10 cycles later press NS -> req=2'b11, oldest=1. ack[1] -> oldest=0, req=2'b01.
- Same-cycle requests: both buttons rise together -> req=2'b11 on the same edge, oldest=0.
- Corner cases:
  - Reset asserted while PENDING with hold-off counting on the other channel -> all outputs 0 asynchronously.
  - ack in IDLE has no effect.
  - press and ack in the same cycle in IDLE gives req=1.

Source files
------------

// File: rtl/crossing_pkg.sv
// Shared constants for the pedestrian crossing-request front end.
// Latency: n/a (constants only).
// Backpressure: n/a.
package crossing_pkg;

    // Per-channel request FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PENDING = 2'b01;
    localparam logic [1:0] ST_HOLD    = 2'b10;

    // Channel indices into btn/ack/req/holdoff/press
    localparam logic CH_NS = 1'b0;
    localparam logic CH_WE = 1'b1;

    // Default build parameters
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_HOLDOFF_S       = 3;
    localparam int DEF_CW              = 5;

endpackage

// File: rtl/crossing_request_if.sv
// Button/handshake bundle between the crossing front end and the light controller.
// Latency: n/a (wiring only).
// Backpressure: none; ack and tick are single-cycle pulses, req/holdoff are levels.
interface crossing_request_if;
    logic [1:0] btn;      // raw buttons, bit0=NS, bit1=WE
    logic       tick;     // 1 s pulse
    logic [1:0] ack;      // controller served channel i
    logic [1:0] req;      // latched request per channel
    logic       oldest;   // earlier pending channel, meaningful when req==2'b11
    logic [1:0] holdoff;  // channel is in post-ack hold-off
    logic [1:0] press;    // accepted debounced rising edge

    modport master (output btn, tick, ack, input req, oldest, holdoff, press);
    modport slave  (input btn, tick, ack, output req, oldest, holdoff, press);
endinterface

// File: rtl/crossing_request_btn_debounce.sv
// Two-flop synchroniser, consecutive-cycle debounce and rising-edge detect for one button.
// Latency: raw level -> stable after DEBOUNCE_CYCLES+2 edges; press_o one edge later.
// Backpressure: none; rise_o is combinational off registers so the FSM can act on the press edge.
module btn_debounce
    import crossing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CW              = DEF_CW
) (
    input  logic CLK,
    input  logic Reset,
    input  logic btn_i,
    output logic rise_o,
    output logic press_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q;

    // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles in a row
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign rise_o  = stable_q & ~stable_dly_q;
    assign press_o = press_q;

    // Synchroniser, debounce state and registered edge pulse
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            press_q      <= rise_o;
        end
    end

endmodule

// File: rtl/crossing_request.sv
// Latches debounced pedestrian presses as requests, applies post-ack hold-off and tracks the oldest request.
// Latency: raw press -> req/press after DEBOUNCE_CYCLES+3 edges; ack -> req drop one edge later.
// Backpressure: none; presses arriving while PENDING or HOLD are dropped.
module crossing_request
    import crossing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLDOFF_S       = DEF_HOLDOFF_S,
    parameter int CW              = DEF_CW
) (
    input  logic               CLK,
    input  logic               Reset,
    crossing_request_if.slave  bus
);

    localparam int HW = ($clog2(HOLDOFF_S + 1) > 0) ? $clog2(HOLDOFF_S + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_S);

    logic [1:0]    rise;
    logic [1:0]    press;
    logic [1:0]    state_q [2];
    logic [1:0]    state_d [2];
    logic [HW-1:0] hcnt_q  [2];
    logic [HW-1:0] hcnt_d  [2];
    logic [1:0]    pend_q, pend_d, hold_d;
    logic [1:0]    enter, leave;
    logic [1:0]    req_q, holdoff_q;
    logic          oldest_q, oldest_d;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CW             (CW)
        ) u_deb (
            .CLK    (CLK),
            .Reset  (Reset),
            .btn_i  (bus.btn[g]),
            .rise_o (rise[g]),
            .press_o(press[g])
        );
    end

    // Per-channel request FSM: IDLE -> PENDING on press, PENDING -> HOLD/IDLE on ack, HOLD counts ticks
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            hcnt_d[i]  = hcnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (rise[i]) state_d[i] = ST_PENDING;
                end
                ST_PENDING: begin
                    if (bus.ack[i]) begin
                        if (HOLDOFF_S == 0) begin
                            state_d[i] = ST_IDLE;
                        end else begin
                            state_d[i] = ST_HOLD;
                            hcnt_d[i]  = HOLD_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.tick) begin
                        if (hcnt_q[i] == HW'(1)) state_d[i] = ST_IDLE;
                        else                     hcnt_d[i]  = hcnt_q[i] - 1'b1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            pend_q[i] = (state_q[i] == ST_PENDING);
            pend_d[i] = (state_d[i] == ST_PENDING);
            hold_d[i] = (state_d[i] == ST_HOLD);
        end
    end

    // Oldest pending channel: set on lone entry, NS on tie, hand over when the oldest is served
    always_comb begin
        enter    = pend_d & ~pend_q;
        leave    = pend_q & ~pend_d;
        oldest_d = oldest_q;
        if (enter == 2'b11) begin
            oldest_d = CH_NS;
        end else if (enter[CH_NS] && !pend_d[CH_WE]) begin
            oldest_d = CH_NS;
        end else if (enter[CH_WE] && !pend_d[CH_NS]) begin
            oldest_d = CH_WE;
        end else if (leave[oldest_q] && pend_d[~oldest_q]) begin
            oldest_d = ~oldest_q;
        end
    end

    // State, hold-off counters and registered outputs
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_IDLE;
                hcnt_q[i]  <= '0;
            end
            req_q     <= '0;
            holdoff_q <= '0;
            oldest_q  <= CH_NS;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
            req_q     <= pend_d;
            holdoff_q <= hold_d;
            oldest_q  <= oldest_d;
        end
    end

    assign bus.req     = req_q;
    assign bus.holdoff = holdoff_q;
    assign bus.oldest  = oldest_q;
    assign bus.press   = press;

endmodule
